// File: rtl/jtdd_colmix_pkg.sv
// Shared definitions for the jtdd colour mixer.
// - Layer base values that sit above the 7-bit layer pixel in the palette address.
// - The transparent pen index.
// - The xBGR 4:4:4 field positions inside a 12-bit palette word.
// - A packed view of a layer pixel, plus an opacity helper.
package jtdd_colmix_pkg;

  localparam logic [1:0] CHAR_BASE  = 2'b00;
  localparam logic [1:0] OBJ_BASE   = 2'b01;
  localparam logic [1:0] SCR_BASE   = 2'b10;

  localparam logic [3:0] TRANSP_IDX = 4'h0;

  // Palette word layout: {x, B[11:8], G[7:4], R[3:0]}.
  localparam int PAL_DW    = 12;
  localparam int COL_W     = 4;
  localparam int R_LSB     = 0;
  localparam int G_LSB     = 4;
  localparam int B_LSB     = 8;
  localparam int LO_BYTE_W = 8;   // {G,R} byte; the B nibble is everything above it

  typedef struct packed {
    logic [2:0] pal;
    logic [3:0] idx;
  } layer_pxl_t;

  // A layer pixel is visible when its layer is enabled and its pen is not transparent.
  function automatic logic opaque(input layer_pxl_t p, input logic en);
    return en && (p.idx != TRANSP_IDX);
  endfunction

endpackage

// File: rtl/jtframe_dual_ram.sv
// Dual-port synchronous RAM used as the colour palette.
// Port A (CPU): read/write, split byte enables: we_lo writes [LO_W-1:0], we_hi writes
//   [DW-1:LO_W]. q_a is registered with one clk of latency.
// Port B (video): read only, q_b updates on clocks where rd_b is high, otherwise holds.
// Both ports are read-before-write: a read of an entry being written on the same clk returns
// the previous contents.
// Ports: clk, rst (async, active high, clears only the output registers), addr_a, data_a,
//   we_lo, we_hi, q_a, addr_b, rd_b, q_b.
module jtframe_dual_ram #(
  parameter int DW   = 12,
  parameter int AW   = 9,
  parameter int LO_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] data_a,
  input  logic          we_lo,
  input  logic          we_hi,
  output logic [DW-1:0] q_a,
  input  logic [AW-1:0] addr_b,
  input  logic          rd_b,
  output logic [DW-1:0] q_b
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [0:DEPTH-1];

  // NOTE: the array itself has no reset so it maps onto block RAM; only the read registers
  // below are cleared.
  always_ff @(posedge clk) begin
    if (we_lo) mem[addr_a][LO_W-1:0] <= data_a[LO_W-1:0];
    if (we_hi) mem[addr_a][DW-1:LO_W] <= data_a[DW-1:LO_W];
  end

  // Read registers sample the array before this clk's write takes effect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_a <= '0;
      q_b <= '0;
    end else begin
      q_a <= mem[addr_a];
      if (rd_b) q_b <= mem[addr_b];
    end
  end

endmodule

// File: rtl/jtdd_colmix.sv
// Pixel colour mixer. Per pixel it picks the visible layer (char > obj > scroll), looks the
// result up in the CPU-written palette and outputs 4-bit RGB. Sync and blank travel through a
// delay line of equal depth, so they reach the outputs aligned with the colour.
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   pxl_cen             pixel clock enable; the video pipeline only advances on it
//   cpu_addr/cpu_dout   palette CPU port: [8:0] entry, [9]=0 {G,R} byte, [9]=1 {4'h0,B}
//   pal_cs/cpu_wrn      chip select and active-low write strobe
//   pal_dout            registered CPU read-back
//   char/obj/scr_pxl    {pal[2:0],idx[3:0]} from each layer
//   gfx_en              layer enables {scr,obj,char}
//   HBL/VBL/HS/VS       timing inputs; *_dly are the same delayed PXL_DLY pxl_cen ticks
//   red/green/blue      colour output, zero while blanking
// The video RAM read is issued on the clk after pxl_cen and its result is captured on the next
// pxl_cen, so pxl_cen must be low for at least one clk between ticks. The colour path is fixed
// at three registers (address, palette word, RGB), so PXL_DLY has to stay at 3.
module jtdd_colmix
  import jtdd_colmix_pkg::*;
#(
  parameter int PXL_DLY = 3,
  parameter int PAL_AW  = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pxl_cen,
  input  logic [PAL_AW:0] cpu_addr,
  input  logic [7:0]      cpu_dout,
  input  logic            pal_cs,
  input  logic            cpu_wrn,
  output logic [7:0]      pal_dout,
  input  logic [6:0]      char_pxl,
  input  logic [6:0]      obj_pxl,
  input  logic [6:0]      scr_pxl,
  input  logic [2:0]      gfx_en,
  input  logic            HBL,
  input  logic            VBL,
  input  logic            HS,
  input  logic            VS,
  output logic [3:0]      red,
  output logic [3:0]      green,
  output logic [3:0]      blue,
  output logic            HBL_dly,
  output logic            VBL_dly,
  output logic            HS_dly,
  output logic            VS_dly
);

  layer_pxl_t char_l, obj_l;
  assign char_l = char_pxl;
  assign obj_l  = obj_pxl;

  logic [PAL_AW-1:0]  pal_addr_d, pal_addr_q;
  logic [PAL_DW-1:0]  vid_word, word_q;
  logic [PAL_DW-1:0]  cpu_word;
  logic [PAL_DW-1:0]  rgb_d, rgb_q;
  logic [PXL_DLY-1:0] hs_sr_q, vs_sr_q, hbl_sr_q, vbl_sr_q;
  logic               cen_q;
  logic               hi_sel_q;
  logic               cpu_we, we_lo, we_hi;
  logic               blank_s3;

  // ---------------------------------------------------------------- layer priority
  // NOTE: default assignment first so every path through the if-chain drives pal_addr_d and
  // no latch is inferred.
  always_comb begin
    pal_addr_d = '0;
    if (opaque(char_l, gfx_en[0]))     pal_addr_d = PAL_AW'({CHAR_BASE, char_pxl});
    else if (opaque(obj_l, gfx_en[1])) pal_addr_d = PAL_AW'({OBJ_BASE,  obj_pxl});
    else if (gfx_en[2])                pal_addr_d = PAL_AW'({SCR_BASE,  scr_pxl});
  end

  // ---------------------------------------------------------------- palette RAM
  assign cpu_we = pal_cs && !cpu_wrn;
  assign we_lo  = cpu_we && !cpu_addr[PAL_AW];
  assign we_hi  = cpu_we &&  cpu_addr[PAL_AW];

  // The B nibble comes from the low bits of the CPU byte, so the same data bus feeds both halves.
  jtframe_dual_ram #(
    .DW   (PAL_DW),
    .AW   (PAL_AW),
    .LO_W (LO_BYTE_W)
  ) u_pal (
    .clk    (clk),
    .rst    (rst),
    .addr_a (cpu_addr[PAL_AW-1:0]),
    .data_a ({cpu_dout[PAL_DW-LO_BYTE_W-1:0], cpu_dout}),
    .we_lo  (we_lo),
    .we_hi  (we_hi),
    .q_a    (cpu_word),
    .addr_b (pal_addr_q),
    .rd_b   (cen_q),       // read once, on the clk after the address was registered
    .q_b    (vid_word)
  );

  // CPU read-back: byte select is registered alongside the RAM read so both line up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hi_sel_q <= 1'b0;
    else     hi_sel_q <= cpu_addr[PAL_AW];
  end

  assign pal_dout = hi_sel_q ? {4'h0, cpu_word[PAL_DW-1:LO_BYTE_W]} : cpu_word[LO_BYTE_W-1:0];

  // ---------------------------------------------------------------- video pipeline
  // The blank bits entering the last delay stage belong to the pixel that is entering the RGB
  // register on the same tick.
  assign blank_s3 = hbl_sr_q[PXL_DLY-2] | vbl_sr_q[PXL_DLY-2];
  assign rgb_d    = blank_s3 ? '0 : word_q;

  // NOTE: non-blocking assignments throughout, so every register samples pre-edge values and
  // the stages shift as one pipeline regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cen_q      <= 1'b0;
      pal_addr_q <= '0;
      word_q     <= '0;
      rgb_q      <= '0;
      hs_sr_q    <= '0;
      vs_sr_q    <= '0;
      hbl_sr_q   <= '1;
      vbl_sr_q   <= '1;
    end else begin
      cen_q <= pxl_cen;
      if (pxl_cen) begin
        pal_addr_q <= pal_addr_d;
        word_q     <= vid_word;
        rgb_q      <= rgb_d;
        hs_sr_q    <= {hs_sr_q[PXL_DLY-2:0],  HS};
        vs_sr_q    <= {vs_sr_q[PXL_DLY-2:0],  VS};
        hbl_sr_q   <= {hbl_sr_q[PXL_DLY-2:0], HBL};
        vbl_sr_q   <= {vbl_sr_q[PXL_DLY-2:0], VBL};
      end
    end
  end

  assign red     = rgb_q[R_LSB +: COL_W];
  assign green   = rgb_q[G_LSB +: COL_W];
  assign blue    = rgb_q[B_LSB +: COL_W];
  assign HS_dly  = hs_sr_q[PXL_DLY-1];
  assign VS_dly  = vs_sr_q[PXL_DLY-1];
  assign HBL_dly = hbl_sr_q[PXL_DLY-1];
  assign VBL_dly = vbl_sr_q[PXL_DLY-1];

endmodule
